// File: rtl/sfrm_pkg.sv
// Shared definitions for the serial frame transmitter and receiver:
// default frame geometry and the shifter state encoding.
package sfrm_pkg;

    localparam int              SFRM_HEADER_SIZE  = 8;
    localparam logic [7:0]      SFRM_HEADER_VALUE = 8'hA5;
    localparam int              SFRM_BODY_SIZE    = 16;
    localparam int              FRAME_BITS        = SFRM_HEADER_SIZE + SFRM_BODY_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } sfrm_state_t;

endpackage

// File: rtl/sfrm_byte_pack.sv
// Byte assembler: packs incoming bytes MSB-byte-first into a holding register
// and flags it full until the shifter takes it.
module sfrm_byte_pack #(
    parameter int BODY_SIZE     = 16,
    parameter int BYTE_CNT_SIZE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           din,
    input  logic                 dvalid,
    input  logic                 load,
    output logic                 dready,
    output logic [BODY_SIZE-1:0] hold,
    output logic                 hfull,
    output logic                 bcnt_nz
);

    localparam int NBYTES = BODY_SIZE / 8;

    logic                     hfull_reg;
    logic [BYTE_CNT_SIZE-1:0] bcnt_reg;
    logic                     accept;

    // Ready is forced low while reset is held, not just after it releases.
    assign dready  = rst_n & ~hfull_reg;
    assign accept  = dvalid & dready;
    assign hfull   = hfull_reg;
    assign bcnt_nz = (bcnt_reg != '0);

    // load only happens while full, and accept only while not full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hfull_reg <= 1'b0;
            bcnt_reg  <= '0;
        end else if (load) begin
            hfull_reg <= 1'b0;
        end else if (accept) begin
            if (bcnt_reg == BYTE_CNT_SIZE'(NBYTES - 1)) begin
                hfull_reg <= 1'b1;
                bcnt_reg  <= '0;
            end else begin
                bcnt_reg  <= bcnt_reg + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_slot
            logic [7:0] slot_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (accept && (bcnt_reg == BYTE_CNT_SIZE'(gi))) begin
                    slot_reg <= din;
                end
            end

            assign hold[BODY_SIZE-1-8*gi -: 8] = slot_reg;
        end
    endgenerate

endmodule

// File: rtl/sfrm_xmit.sv
// Serial frame transmitter: sends HEADER_VALUE then the assembled body on
// SDATA, MSB-first, with optional idle gap between frames.
module sfrm_xmit
    import sfrm_pkg::*;
#(
    parameter int                     HEADER_SIZE   = SFRM_HEADER_SIZE,
    parameter logic [HEADER_SIZE-1:0] HEADER_VALUE  = SFRM_HEADER_VALUE,
    parameter int                     BODY_SIZE     = SFRM_BODY_SIZE,
    parameter int                     GAP_BITS      = 0,
    parameter int                     COUNTER_SIZE  = 5,
    parameter int                     BYTE_CNT_SIZE = 1
) (
    input  logic       SCLK,
    input  logic       RST_N,
    input  logic [7:0] DIN,
    input  logic       DVALID,
    output logic       DREADY,
    output logic       SDATA,
    output logic       SOF,
    output logic       BUSY
);

    localparam int FRAME_LEN = HEADER_SIZE + BODY_SIZE;
    localparam int GAP_LAST  = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

    sfrm_state_t              state_reg, state_next;
    logic [FRAME_LEN-1:0]     shift_reg, shift_next;
    logic [COUNTER_SIZE-1:0]  count_reg, count_next;
    logic                     sdata_reg, sdata_next;
    logic                     sof_reg, sof_next;
    logic                     load;
    logic [BODY_SIZE-1:0]     hold;
    logic                     hfull;
    logic                     bcnt_nz;

    sfrm_byte_pack #(
        .BODY_SIZE     (BODY_SIZE),
        .BYTE_CNT_SIZE (BYTE_CNT_SIZE)
    ) u_pack (
        .clk     (SCLK),
        .rst_n   (RST_N),
        .din     (DIN),
        .dvalid  (DVALID),
        .load    (load),
        .dready  (DREADY),
        .hold    (hold),
        .hfull   (hfull),
        .bcnt_nz (bcnt_nz)
    );

    always_ff @(posedge SCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            count_reg <= '0;
            sdata_reg <= 1'b0;
            sof_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            count_reg <= count_next;
            sdata_reg <= sdata_next;
            sof_reg   <= sof_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        count_next = count_reg;
        sdata_next = 1'b0;
        sof_next   = 1'b0;
        load       = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (hfull) begin
                    load       = 1'b1;
                    shift_next = {HEADER_VALUE, hold};
                    count_next = '0;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sdata_next = shift_reg[FRAME_LEN-1];
                sof_next   = (count_reg == '0);
                shift_next = shift_reg << 1;
                count_next = count_reg + 1'b1;
                if (count_reg == COUNTER_SIZE'(FRAME_LEN - 1)) begin
                    count_next = '0;
                    if (GAP_BITS > 0) begin
                        state_next = ST_GAP;
                    end else if (hfull) begin
                        // Reload in place so the next header follows with no idle bit.
                        load       = 1'b1;
                        shift_next = {HEADER_VALUE, hold};
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                count_next = count_reg + 1'b1;
                if (count_reg == COUNTER_SIZE'(GAP_LAST)) begin
                    count_next = '0;
                    if (hfull) begin
                        load       = 1'b1;
                        shift_next = {HEADER_VALUE, hold};
                        state_next = ST_SHIFT;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign SDATA = sdata_reg;
    assign SOF   = sof_reg;
    assign BUSY  = (state_reg != ST_IDLE) || hfull || bcnt_nz;

endmodule

// File: tb/tb_sfrm_xmit.sv
// Testbench for sfrm_xmit: back-to-back instance (GAP_BITS=0) and a gapped
// instance (GAP_BITS=3); frames are scoreboarded against SOF-aligned capture.
module tb_sfrm_xmit;

    logic       sclk = 1'b0;
    logic       rst_n;
    logic [7:0] din, din3;
    logic       dvalid, dvalid3;
    logic       dready, sdata, sof, busy;
    logic       dready3, sdata3, sof3, busy3;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [23:0] exp_q[$];
    logic [23:0] exp3_q[$];
    int          sof_q[$];
    int          sof3_q[$];

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    sfrm_xmit #(.GAP_BITS(0)) dut (
        .SCLK(sclk), .RST_N(rst_n), .DIN(din), .DVALID(dvalid),
        .DREADY(dready), .SDATA(sdata), .SOF(sof), .BUSY(busy)
    );

    sfrm_xmit #(.GAP_BITS(3)) dut3 (
        .SCLK(sclk), .RST_N(rst_n), .DIN(din3), .DVALID(dvalid3),
        .DREADY(dready3), .SDATA(sdata3), .SOF(sof3), .BUSY(busy3)
    );

    // Scoreboard monitor for the back-to-back instance.
    int          cap_cnt = 0;
    logic [23:0] cap_word;
    always @(negedge sclk) begin
        if (!rst_n) begin
            cap_cnt = 0;
        end else if (cap_cnt == 0) begin
            if (sof === 1'b1) begin
                cap_word = 24'(sdata);
                cap_cnt  = 1;
                sof_q.push_back(cyc);
            end else if (sdata !== 1'b0) begin
                vectors++; miscompares++;
                $display("FAIL stray_bit: sdata=%b outside frame, required 0 (cyc %0d)", sdata, cyc);
            end
        end else begin
            if (sof !== 1'b0) begin
                vectors++; miscompares++;
                $display("FAIL sof_mid_frame: sof=%b at bit %0d, required 0", sof, cap_cnt);
            end
            cap_word = {cap_word[22:0], sdata};
            cap_cnt++;
            if (cap_cnt == 24) begin
                cap_cnt = 0;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL frame: got %h, no frame expected", cap_word);
                end else begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    if (cap_word !== e) begin
                        miscompares++;
                        $display("FAIL frame: got %h, required %h", cap_word, e);
                    end else begin
                        $display("frame ok: %h (cyc %0d)", cap_word, cyc);
                    end
                end
            end
        end
    end

    // Scoreboard monitor for the gapped instance.
    int          cap3_cnt = 0;
    logic [23:0] cap3_word;
    always @(negedge sclk) begin
        if (!rst_n) begin
            cap3_cnt = 0;
        end else if (cap3_cnt == 0) begin
            if (sof3 === 1'b1) begin
                cap3_word = 24'(sdata3);
                cap3_cnt  = 1;
                sof3_q.push_back(cyc);
            end else if (sdata3 !== 1'b0) begin
                vectors++; miscompares++;
                $display("FAIL stray_bit_gap: sdata=%b outside frame, required 0 (cyc %0d)", sdata3, cyc);
            end
        end else begin
            if (sof3 !== 1'b0) begin
                vectors++; miscompares++;
                $display("FAIL sof_mid_frame_gap: sof=%b at bit %0d, required 0", sof3, cap3_cnt);
            end
            cap3_word = {cap3_word[22:0], sdata3};
            cap3_cnt++;
            if (cap3_cnt == 24) begin
                cap3_cnt = 0;
                vectors++;
                if (exp3_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL frame_gap: got %h, no frame expected", cap3_word);
                end else begin
                    logic [23:0] e;
                    e = exp3_q.pop_front();
                    if (cap3_word !== e) begin
                        miscompares++;
                        $display("FAIL frame_gap: got %h, required %h", cap3_word, e);
                    end else begin
                        $display("frame ok (gap dut): %h (cyc %0d)", cap3_word, cyc);
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input int which, input logic [7:0] b, output int hs);
        int n = 0;
        if (which == 0) begin din = b; dvalid = 1'b1; end
        else begin din3 = b; dvalid3 = 1'b1; end
        while (((which == 0) ? dready : dready3) !== 1'b1 && n < 500) begin
            @(negedge sclk);
            n++;
        end
        if (n >= 500) begin
            vectors++; miscompares++;
            $display("FAIL handshake_timeout: byte %h not accepted after %0d cycles, required accept", b, n);
        end
        @(negedge sclk);
        hs = cyc;
    endtask

    task automatic wait_sof(output int sc);
        int n = 0;
        while (sof !== 1'b1 && n < 100) begin
            @(negedge sclk);
            n++;
        end
        if (n >= 100) begin
            vectors++; miscompares++;
            $display("FAIL sof_timeout: no SOF in %0d cycles, required SOF", n);
        end
        sc = cyc;
    endtask

    task automatic wait_drain(input int which);
        int n = 0;
        while (((which == 0) ? (exp_q.size() != 0 || busy !== 1'b0)
                             : (exp3_q.size() != 0 || busy3 !== 1'b0)) && n < 400) begin
            @(negedge sclk);
            n++;
        end
        vectors++;
        if (n >= 400) begin
            miscompares++;
            $display("FAIL drain_timeout: dut%0d still busy after %0d cycles, required idle", which, n);
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({sdata, sof, dready, busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_state: sdata/sof/dready/busy=%b, required 0000", {sdata, sof, dready, busy});
        end
        vectors++;
        if ({sdata3, sof3, dready3, busy3} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_state_gap: sdata/sof/dready/busy=%b, required 0000", {sdata3, sof3, dready3, busy3});
        end
        @(negedge sclk);
        rst_n = 1'b1;
        @(negedge sclk);
        vectors++;
        if (dready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: dready=%b, required 1", dready);
        end
    endtask

    task automatic test_single();
        int hs, sc;
        send_byte(0, 8'h12, hs);
        send_byte(0, 8'h34, hs);
        dvalid = 1'b0;
        exp_q.push_back(24'hA51234);
        wait_sof(sc);
        vectors++;
        if (sc - hs != 2) begin
            miscompares++;
            $display("FAIL sof_latency: %0d cycles after handshake, required 2", sc - hs);
        end
        repeat (24) @(negedge sclk);
        vectors++;
        if ({sdata, busy, sof} !== 3'b000) begin
            miscompares++;
            $display("FAIL after_frame: sdata/busy/sof=%b, required 000", {sdata, busy, sof});
        end
        $display("single frame 12 34 done");
    endtask

    task automatic test_header_in_body();
        int hs;
        send_byte(0, 8'hA5, hs);
        send_byte(0, 8'h5A, hs);
        dvalid = 1'b0;
        exp_q.push_back(24'hA5A55A);
        wait_drain(0);
        $display("header-pattern body done");
    endtask

    task automatic test_back_to_back();
        int hs;
        logic [7:0] b0, b1;
        sof_q.delete();
        for (int f = 0; f < 4; f++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            send_byte(0, b0, hs);
            send_byte(0, b1, hs);
            exp_q.push_back({8'hA5, b0, b1});
        end
        dvalid = 1'b0;
        wait_drain(0);
        vectors++;
        if (sof_q.size() != 4) begin
            miscompares++;
            $display("FAIL b2b_sof_count: %0d SOFs, required 4", sof_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (sof_q[i] - sof_q[i-1] != 24) begin
                    miscompares++;
                    $display("FAIL b2b_spacing: frame %0d SOF spacing %0d, required 24", i, sof_q[i] - sof_q[i-1]);
                end
            end
        end
        $display("back-to-back 4 frames done");
    endtask

    task automatic test_gap();
        int hs;
        sof3_q.delete();
        send_byte(1, 8'hC0, hs);
        send_byte(1, 8'hDE, hs);
        exp3_q.push_back(24'hA5C0DE);
        send_byte(1, 8'h81, hs);
        send_byte(1, 8'h7E, hs);
        exp3_q.push_back(24'hA5817E);
        dvalid3 = 1'b0;
        wait_drain(1);
        vectors++;
        if (sof3_q.size() != 2) begin
            miscompares++;
            $display("FAIL gap_sof_count: %0d SOFs, required 2", sof3_q.size());
        end else begin
            vectors++;
            if (sof3_q[1] - sof3_q[0] != 27) begin
                miscompares++;
                $display("FAIL gap_spacing: SOF spacing %0d, required 27", sof3_q[1] - sof3_q[0]);
            end
        end
        $display("gap frames done");
    endtask

    task automatic test_reset_mid_frame();
        int hs, sc;
        send_byte(0, 8'hDE, hs);
        send_byte(0, 8'hAD, hs);
        dvalid = 1'b0;
        exp_q.push_back(24'hA5DEAD);
        wait_sof(sc);
        repeat (10) @(negedge sclk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({sdata, dready, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_reset: sdata/dready/busy=%b, required 000", {sdata, dready, busy});
        end
        exp_q.delete();
        @(negedge sclk);
        @(negedge sclk);
        rst_n = 1'b1;
        @(negedge sclk);
        send_byte(0, 8'hFF, hs);
        send_byte(0, 8'h00, hs);
        dvalid = 1'b0;
        exp_q.push_back(24'hA5FF00);
        wait_drain(0);
        $display("reset mid-frame done");
    endtask

    task automatic test_partial();
        int hs;
        int bad = 0;
        send_byte(0, 8'h5A, hs);
        dvalid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge sclk);
            if (sdata !== 1'b0 || busy !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL partial_hold: %0d cycles with sdata!=0 or busy!=1, required 0", bad);
        end
        send_byte(0, 8'hC3, hs);
        dvalid = 1'b0;
        exp_q.push_back(24'hA55AC3);
        wait_drain(0);
        $display("partial assembly done");
    endtask

    initial begin
        rst_n   = 1'b0;
        din     = '0;
        din3    = '0;
        dvalid  = 1'b0;
        dvalid3 = 1'b0;
        @(negedge sclk);
        test_reset();
        test_single();
        test_header_in_body();
        test_back_to_back();
        test_gap();
        test_reset_mid_frame();
        test_partial();
        repeat (5) @(negedge sclk);
        vectors++;
        if (exp_q.size() != 0 || exp3_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: %0d/%0d frames outstanding, required 0/0", exp_q.size(), exp3_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sfrm_xmit.md
Name: sfrm_xmit

Overview:
Serial frame transmitter; the upstream peer of the serial frame receiver. It accepts body bytes over a valid/ready byte interface and packs them into a double-buffered frame. It then emits HEADER_VALUE followed by the body on SDATA, MSB-first, one bit per SCLK. Frames are emitted back-to-back when data is available, with an optional fixed idle gap.

Parameters:
HEADER_SIZE, 8, header width in bits.
HEADER_VALUE, 8'hA5, header pattern sent before every body.
BODY_SIZE, 16, body width in bits; must be a non-zero multiple of 8.
GAP_BITS, 0, number of SDATA=0 idle bits forced after each frame (0 = back-to-back allowed).
COUNTER_SIZE, 5, bit-counter width; must hold HEADER_SIZE+BODY_SIZE-1 and GAP_BITS-1.
BYTE_CNT_SIZE, 1, byte-index width; must hold BODY_SIZE/8-1.

Ports:
SCLK  input  1  serial clock; all state changes on rising edge.
RST_N  input  1  asynchronous, active-low reset.
DIN  input  8  body byte; the first byte of a frame is the body MSB byte.
DVALID  input  1  DIN valid.
DREADY  output  1  byte accepted on an edge where DVALID && DREADY.
SDATA  output  1  registered serial output; 0 when not shifting.
SOF  output  1  registered; high for the cycle the first header bit is on SDATA.
BUSY  output  1  high while any frame is partially assembled, pending or being shifted.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE, SDATA=0, SOF=0, hfull=0, bcnt=0, shift/count cleared.
  - DREADY=0 while RST_N is low; BUSY=0.
  - Reset mid-frame discards the frame; SDATA is 0 immediately.
- Assembly (holding register hold[BODY_SIZE-1:0]):
  - DREADY = !hfull.
  - Accepted byte is written to slot bcnt, where bcnt 0 is the top byte; then bcnt++.
  - Accepting the last byte (bcnt == BODY_SIZE/8-1) sets hfull=1 and bcnt=0.
  - Bytes are never accepted while hfull=1. No back-pressure depends on the shifter except through hfull.
- Shifter FSM states:
  - IDLE: if hfull, then on the next edge load shift <= {HEADER_VALUE, hold}, clear hfull, count=0, go to SHIFT.
  - SHIFT: SDATA <= shift MSB each edge, shift <<= 1, count++.
    - On the edge that outputs bit HEADER_SIZE+BODY_SIZE-1 (the last body bit):
      - if GAP_BITS > 0: go to GAP, count=0.
      - else if hfull: reload in place (next edge outputs the new header MSB).
      - else: go to IDLE.
  - GAP: SDATA=0 for exactly GAP_BITS cycles, then reload if hfull, else go to IDLE.
- Latency:
  - Last byte accepted at edge E.
  - hfull=1 after E; load at edge E+1.
  - Header MSB is on SDATA from edge E+2 with SOF=1.
  - Frame occupies exactly HEADER_SIZE+BODY_SIZE consecutive cycles.
- Simultaneous events:
  - Reload and byte acceptance can coincide. The reload clears hfull on the same edge a byte would be written; no byte is accepted that cycle because DREADY=0. Clearing hfull re-opens DREADY for the next cycle.
  - With GAP_BITS=0 and continuous DVALID, sustained throughput is one frame per HEADER_SIZE+BODY_SIZE cycles, with no idle bit.
- Width rules: count wraps only via explicit clear; no arithmetic overflow is permitted under legal parameters.
- BUSY = (state != IDLE) || hfull || (bcnt != 0).

Decomposition:
- Package sfrm_pkg: HEADER_SIZE/HEADER_VALUE/BODY_SIZE defaults shared with the receiver, the state encoding (IDLE=0, SHIFT=1, GAP=2), and a FRAME_BITS constant.
- One natural sub-module: sfrm_byte_pack, the byte assembler (hold, bcnt, hfull, DREADY). The top level keeps the FSM and shifter.

Test Plan:
- Single frame: bytes 0x12, 0x34 -> SDATA = 10100101 00010010 00110100 starting 2 cycles after the 0x34 handshake. SOF pulses once; then SDATA=0 and BUSY falls.
- Loopback into the serial receiver (active-high reset driven by !RST_N):
  - Send 0xA5, 0x5A as the body -> receiver READY rises with DOUT=0xA5; after ACK, DOUT=0x5A; after the second ACK, READY=0.
  - The body contains the header pattern without false resync.
- Back-to-back, GAP_BITS=0: 4 frames streamed with DVALID held high -> 96 contiguous bits, SOF every 24 cycles. DREADY low except in the windows after each load.
- GAP_BITS=3: two frames -> exactly 3 zero bits between the last body bit and the next header MSB.
- Reset mid-frame: assert RST_N low after 10 bits -> SDATA=0, DREADY=0 and BUSY=0 immediately. After release, a new frame 0xFF, 0x00 is sent correctly with no remnant bits.
- Partial assembly: one byte accepted, DVALID low for 50 cycles -> no SDATA activity, BUSY=1. The second byte then triggers a normal frame.
